// File: rtl/rx_meta_aligner.sv
// rx_meta_aligner
//   Queues one metadata record per packet and holds the head record on its
//   outputs while that packet's AXI-Stream beats pass through. The stream is
//   gated combinationally, so beats stall until their record is queued. On
//   each tail beat the streamed byte count is compared with payload_len.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_meta_*                metadata push from the parser (one pulse per packet)
//   s_axis_*                 payload stream in
//   m_axis_*                 payload stream out toward fast_path
//   dst_port .. meta_valid   head FIFO record
//   meta_count               FIFO occupancy
//   meta_overflow_cnt        records refused while full (saturating)
//   len_err, len_err_cnt     byte-count mismatch pulse and saturating count
module rx_meta_aligner #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int META_DEPTH     = 4,
    localparam int KW            = AXI_DATA_WIDTH / 8,
    localparam int AW            = $clog2(META_DEPTH),
    localparam int CW            = $clog2(META_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_meta_valid,
    output logic                      in_meta_ready,
    input  logic [15:0]               in_dst_port,
    input  logic [15:0]               in_payload_len,
    input  logic [15:0]               in_ip_checksum,
    input  logic [15:0]               in_udp_checksum,
    input  logic                      in_drop_flag,
    input  logic                      in_checksum_valid,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KW-1:0]             s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KW-1:0]             m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [15:0]               dst_port,
    output logic [15:0]               payload_len,
    output logic [15:0]               ip_checksum,
    output logic [15:0]               udp_checksum,
    output logic                      drop_flag,
    output logic                      checksum_valid,
    output logic                      meta_valid,
    output logic [CW-1:0]             meta_count,
    output logic [15:0]               meta_overflow_cnt,
    output logic                      len_err,
    output logic [15:0]               len_err_cnt
);

    typedef struct packed {
        logic [15:0] dst_port;
        logic [15:0] payload_len;
        logic [15:0] ip_checksum;
        logic [15:0] udp_checksum;
        logic        drop_flag;
        logic        checksum_valid;
    } meta_t;

    typedef enum logic {WAIT_META = 1'b0, IN_PKT = 1'b1} state_t;

    meta_t         mem_q [META_DEPTH];
    meta_t         head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   ovf_q, lerr_cnt_q;
    logic          len_err_q, len_err_d;
    state_t        state_q, state_d;

    logic          full, push, pop, beat;
    logic [15:0]   beat_bytes, beat_total;
    logic [16:0]   sum17;

    assign full          = (count_q == CW'(META_DEPTH));
    assign in_meta_ready = !full;
    assign meta_valid    = (count_q != '0);

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push = in_meta_valid && !full;
    assign pop  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign beat = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = s_axis_tvalid && meta_valid;
    assign s_axis_tready = m_axis_tready && meta_valid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    assign head           = mem_q[rd_ptr_q];
    assign dst_port       = head.dst_port;
    assign payload_len    = head.payload_len;
    assign ip_checksum    = head.ip_checksum;
    assign udp_checksum   = head.udp_checksum;
    assign drop_flag      = head.drop_flag;
    assign checksum_valid = head.checksum_valid;

    assign meta_count        = count_q;
    assign meta_overflow_cnt = ovf_q;
    assign len_err           = len_err_q;
    assign len_err_cnt       = lerr_cnt_q;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) beat_bytes = beat_bytes + 16'(s_axis_tkeep[i]);
    end

    // Running byte total including the current beat, saturated at 16 bits.
    assign sum17      = {1'b0, acc_q} + {1'b0, beat_bytes};
    assign beat_total = sum17[16] ? 16'hFFFF : sum17[15:0];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        len_err_d = 1'b0;
        if (beat) begin
            if (s_axis_tlast) begin
                acc_d     = '0;
                len_err_d = (beat_total != head.payload_len);
            end else begin
                acc_d = beat_total;
            end
        end
    end

    // Packet tracking; a single-beat packet stays in WAIT_META.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_META: if (beat && !s_axis_tlast) state_d = IN_PKT;
            IN_PKT:    if (beat && s_axis_tlast)  state_d = WAIT_META;
            default:   state_d = WAIT_META;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < META_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= '0;
            lerr_cnt_q <= '0;
            len_err_q  <= 1'b0;
            state_q    <= WAIT_META;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{in_dst_port, in_payload_len, in_ip_checksum,
                                     in_udp_checksum, in_drop_flag, in_checksum_valid};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (in_meta_valid && full && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 1'b1;
            if (len_err_d && lerr_cnt_q != 16'hFFFF) lerr_cnt_q <= lerr_cnt_q + 1'b1;
            count_q   <= count_d;
            acc_q     <= acc_d;
            len_err_q <= len_err_d;
            state_q   <= state_d;
        end
    end

endmodule

// File: doc/rx_meta_aligner.md
# rx_meta_aligner

Per-packet metadata aligner between the RX parser/ACL stage and `fast_path`. It queues one metadata record per packet in a small FIFO. While that packet's AXI-Stream beats pass through, it holds the record stable on its outputs, so the downstream `dst_port`, `payload_len`, `drop_flag`, checksums and `meta_valid` inputs are valid for the whole packet. It also checks the streamed byte count against `payload_len` and keeps overflow and length-error statistics.

## Interface

Parameters:
- `AXI_DATA_WIDTH`, 32: stream data width in bits; a multiple of 8.
- `META_DEPTH`, 4: number of metadata FIFO entries; a power of 2, at least 2.

Ports (`CW` = $clog2(META_DEPTH)+1):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_meta_valid` in 1: one-cycle pulse, one per packet, from the parser.
- `in_meta_ready` out 1: equals `!full`.
- `in_dst_port`, `in_payload_len`, `in_ip_checksum`, `in_udp_checksum` in 16 each: metadata fields.
- `in_drop_flag`, `in_checksum_valid` in 1 each: metadata flags.
- `s_axis_tdata` in AXI_DATA_WIDTH, `s_axis_tkeep` in AXI_DATA_WIDTH/8, `s_axis_tlast` in 1, `s_axis_tvalid` in 1, `s_axis_tready` out 1: payload stream input.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tvalid` out, `m_axis_tready` in: payload stream output toward `fast_path`.
- `dst_port`, `payload_len`, `ip_checksum`, `udp_checksum` out 16 each; `drop_flag`, `checksum_valid`, `meta_valid` out 1 each: head FIFO entry.
- `meta_count` out CW: current FIFO occupancy.
- `meta_overflow_cnt` out 16: metadata records dropped because the FIFO was full; saturates at 0xFFFF.
- `len_err` out 1: one-cycle pulse on a byte-count mismatch.
- `len_err_cnt` out 16: mismatch count; saturates at 0xFFFF.

## Operation

Metadata FIFO:
- A push happens when `in_meta_valid && in_meta_ready`. It writes the record at the write pointer and increments the pointer; pointers wrap modulo `META_DEPTH`.
- A record presented when `in_meta_valid && !in_meta_ready` is discarded and `meta_overflow_cnt` increments.
- A push while full is refused even if a pop happens in the same cycle.
- A pop happens on the tail beat: `m_axis_tvalid && m_axis_tready && m_axis_tlast`.
- Push and pop in the same cycle (not full) leave `meta_count` unchanged; both pointers advance.

Head outputs:
- The head entry always drives the metadata outputs.
- `meta_valid = (meta_count != 0)`.
- Outputs remain constant from the first beat to the tail beat of the packet.

Stream gating (combinational, zero latency):
- `m_axis_tvalid = s_axis_tvalid && meta_valid`.
- `s_axis_tready = m_axis_tready && meta_valid`.
- `tdata`, `tkeep` and `tlast` pass straight through.
- Beats arriving with no queued metadata are stalled, never dropped.

State machine:
- `WAIT_META`: entered on reset. Go to `IN_PKT` on the first accepted beat that is not also a tail beat.
- `IN_PKT`: return to `WAIT_META` on the tail beat.
- A single-beat packet never leaves `WAIT_META`.

Length check:
- The byte accumulator (16 bits) adds popcount(`tkeep`) on every accepted beat and saturates at 0xFFFF.
- On the tail beat, it compares (accumulator + that beat's popcount, saturated) with the head entry's `payload_len`.
- On mismatch: `len_err` pulses the next cycle and `len_err_cnt` increments.
- The accumulator clears to 0 after the tail beat.
- The check is informational only: data and metadata still pass.

## Timing

- Stream path: 0 cycles from input to output; handshakes are combinational.
- Metadata push: a record pushed in cycle N is visible on the outputs, with `meta_valid`=1, in cycle N+1.
- Pop on a tail beat in cycle N: the next record appears in N+1. If the FIFO is then empty, `meta_valid`=0 in N+1.
- Back-to-back packets: the first beat of the next packet is accepted as early as cycle N+1. No beat is accepted in N against the old record.
- `len_err` is registered: it asserts in the cycle after the tail beat, for exactly one cycle.

Reset (`rst`=1 at a clock edge, including mid-packet):
- Pointers, `meta_count`, accumulator, the state machine (to `WAIT_META`), both counters and `len_err` go to 0.
- FIFO storage is cleared to 0, so the metadata outputs read 0.
- `meta_valid`=0, hence `s_axis_tready`=0 and `m_axis_tvalid`=0.
- `in_meta_ready`=1.
- A packet in flight is abandoned; beats arriving after reset stall until new metadata arrives.

## Test plan

- Single packet: push meta {`dst_port`=0x0050, `payload_len`=16}, then 4 beats with `tkeep`=0xF. Expect the beats forwarded unchanged, `dst_port`=0x0050 held throughout, `meta_valid`=0 the cycle after `tlast`, `len_err_cnt`=0.
- Data before meta: assert `s_axis_tvalid` for 5 cycles with no meta. Expect `s_axis_tready`=0 and `m_axis_tvalid`=0. Push meta in cycle 5; the first beat is accepted in cycle 6.
- Overflow: 5 meta pulses with no stream, `META_DEPTH`=4. Expect `meta_count`=4, `in_meta_ready`=0, `meta_overflow_cnt`=1; the 4 queued records pop later in order.
- Back-to-back and simultaneous push/pop: with 2 entries queued, push a third in the tail-beat cycle of packet 1. Expect `meta_count` to stay 2 and the second record to appear the cycle after `tlast`.
- Length mismatch: `payload_len`=16, 3 beats with `tkeep` 0xF, 0xF, 0x3 (10 bytes). Expect a `len_err` pulse one cycle after `tlast`, `len_err_cnt`=1, and data still forwarded.
- Backpressure and reset: hold `m_axis_tready`=0 for 3 cycles mid-packet. Expect `s_axis_tready`=0 and the metadata outputs stable. Then assert `rst` mid-packet: all outputs reach their reset values on the next edge and `meta_valid`=0.
